// File: rtl/csi_raw_unpacker.sv
// Unpacks CSI-2 RAW10 / RAW8 long packets from 4-byte receiver words into
// groups of four 10-bit pixels, with line markers and a per-frame line counter.
module csi_raw_unpacker #(
    parameter int LINE_BITS   = 11,
    parameter bit ACCEPT_RAW8 = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0][7:0]      image_data,
    input  logic [5:0]           image_data_type,
    input  logic                 image_data_enable,
    input  logic [15:0]          word_count,
    input  logic                 frame_start,
    input  logic                 frame_end,
    output logic [3:0][9:0]      pixel,
    output logic                 pixel_enable,
    output logic                 line_start,
    output logic                 line_end,
    output logic [LINE_BITS-1:0] line_number,
    output logic                 frame_start_out,
    output logic                 frame_end_out,
    output logic                 format_err
);

    typedef enum logic [1:0] {IDLE, RAW10, RAW8, DROP} state_t;

    state_t          state_q, state_d;
    logic [15:0]     rem_q, rem_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0][7:0] buf_q, buf_d;
    logic            first_q, first_d;

    logic [3:0][9:0] pixel_d;
    logic            pixel_enable_d, line_start_d, line_end_d, format_err_d;

    logic [2:0]      take;
    logic [15:0]     rem_left;
    logic            last;
    logic [3:0]      fill;
    logic [2:0]      idx;
    logic [7:0][7:0] merged;

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        cnt_d          = cnt_q;
        buf_d          = buf_q;
        first_d        = first_q;
        format_err_d   = format_err;
        pixel_d        = '0;
        pixel_enable_d = 1'b0;
        line_start_d   = 1'b0;
        line_end_d     = 1'b0;
        take           = '0;
        rem_left       = '0;
        last           = 1'b0;
        fill           = '0;
        idx            = '0;
        merged         = buf_q;

        // frame_start takes effect before any word arriving in the same cycle
        if (frame_start) begin
            state_d      = IDLE;
            rem_d        = '0;
            cnt_d        = '0;
            format_err_d = 1'b0;
        end

        if (image_data_enable) begin
            if (state_d == IDLE) begin
                rem_d   = word_count;
                cnt_d   = '0;
                first_d = 1'b1;
                case (image_data_type)
                    6'h2B:   state_d = RAW10;
                    6'h2A:   state_d = ACCEPT_RAW8 ? RAW8 : DROP;
                    default: state_d = DROP;
                endcase
                if (word_count == 16'd0 && state_d != DROP) begin
                    format_err_d = 1'b1;
                end
            end

            take     = (rem_d >= 16'd4) ? 3'd4 : rem_d[2:0];
            rem_left = rem_d - 16'(take);
            last     = (take != 3'd0) && (rem_left == 16'd0);

            case (state_d)
                RAW10: begin
                    merged = buf_q;
                    for (int j = 0; j < 4; j++) begin
                        idx = cnt_d[2:0] + 3'(j);
                        if (3'(j) < take) begin
                            merged[idx] = image_data[j];
                        end
                    end
                    fill  = cnt_d + 4'(take);
                    buf_d = merged;
                    if (fill >= 4'd5) begin
                        for (int i = 0; i < 4; i++) begin
                            pixel_d[i] = {merged[i], merged[4][2*i +: 2]};
                        end
                        pixel_enable_d = 1'b1;
                        line_start_d   = first_d;
                        line_end_d     = last;
                        first_d        = 1'b0;
                        fill           = fill - 4'd5;
                        buf_d          = '0;
                        for (int i = 0; i < 3; i++) begin
                            buf_d[i] = merged[i+5];
                        end
                    end
                    // leftover bytes of a non-multiple-of-5 line are discarded
                    if (last && fill != 4'd0) begin
                        format_err_d = 1'b1;
                        fill         = '0;
                    end
                    cnt_d = fill;
                end
                RAW8: begin
                    if (take != 3'd0) begin
                        for (int j = 0; j < 4; j++) begin
                            if (3'(j) < take) begin
                                pixel_d[j] = {image_data[j], 2'b00};
                            end
                        end
                        pixel_enable_d = 1'b1;
                        line_start_d   = first_d;
                        line_end_d     = last;
                        first_d        = 1'b0;
                    end
                end
                default: ;
            endcase

            rem_d = rem_left;
            if (rem_left == 16'd0) begin
                state_d = IDLE;
            end
        end

        if (frame_end) begin
            state_d = IDLE;
            rem_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            rem_q           <= '0;
            cnt_q           <= '0;
            buf_q           <= '0;
            first_q         <= 1'b0;
            pixel           <= '0;
            pixel_enable    <= 1'b0;
            line_start      <= 1'b0;
            line_end        <= 1'b0;
            line_number     <= '0;
            frame_start_out <= 1'b0;
            frame_end_out   <= 1'b0;
            format_err      <= 1'b0;
        end else begin
            state_q         <= state_d;
            rem_q           <= rem_d;
            cnt_q           <= cnt_d;
            buf_q           <= buf_d;
            first_q         <= first_d;
            pixel           <= pixel_d;
            pixel_enable    <= pixel_enable_d;
            line_start      <= line_start_d;
            line_end        <= line_end_d;
            frame_start_out <= frame_start;
            frame_end_out   <= frame_end;
            format_err      <= format_err_d;
            if (frame_start) begin
                line_number <= '0;
            end else if (line_end && line_number != {LINE_BITS{1'b1}}) begin
                line_number <= line_number + LINE_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_csi_raw_unpacker.sv
// Scoreboard bench for csi_raw_unpacker: directed packets push expected pixel
// groups; a negedge monitor pops and compares whenever pixel_enable is high.
module tb_csi_raw_unpacker;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0][7:0] image_data;
    logic [5:0]      image_data_type;
    logic            image_data_enable;
    logic [15:0]     word_count;
    logic            frame_start;
    logic            frame_end;
    logic [3:0][9:0] pixel;
    logic            pixel_enable;
    logic            line_start;
    logic            line_end;
    logic [10:0]     line_number;
    logic            frame_start_out;
    logic            frame_end_out;
    logic            format_err;

    int checksDone   = 0;
    int checksPassed = 0;

    typedef struct packed {
        logic [3:0][9:0] pix;
        logic            ls;
        logic            le;
        logic [10:0]     ln;
    } group_t;

    group_t expQ[$];
    logic [7:0] c [20];

    always #5 clk = ~clk;

    csi_raw_unpacker dut (
        .clk               (clk),
        .reset             (reset),
        .image_data        (image_data),
        .image_data_type   (image_data_type),
        .image_data_enable (image_data_enable),
        .word_count        (word_count),
        .frame_start       (frame_start),
        .frame_end         (frame_end),
        .pixel             (pixel),
        .pixel_enable      (pixel_enable),
        .line_start        (line_start),
        .line_end          (line_end),
        .line_number       (line_number),
        .frame_start_out   (frame_start_out),
        .frame_end_out     (frame_end_out),
        .format_err        (format_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checksDone++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic logic [3:0][7:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
        logic [3:0][7:0] w;
        w[0] = b0; w[1] = b1; w[2] = b2; w[3] = b3;
        return w;
    endfunction

    function automatic logic [3:0][9:0] grp(input logic [9:0] p0, input logic [9:0] p1,
                                            input logic [9:0] p2, input logic [9:0] p3);
        logic [3:0][9:0] g;
        g[0] = p0; g[1] = p1; g[2] = p2; g[3] = p3;
        return g;
    endfunction

    function automatic logic [3:0][9:0] r10(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3,
                                            input logic [7:0] b4);
        logic [3:0][7:0] b;
        logic [3:0][9:0] p;
        b = mk(b0, b1, b2, b3);
        for (int i = 0; i < 4; i++) p[i] = {b[i], b4[2*i +: 2]};
        return p;
    endfunction

    task automatic pushGroup(input logic [3:0][9:0] p, input logic ls, input logic le, input int ln);
        group_t g;
        g.pix = p; g.ls = ls; g.le = le; g.ln = 11'(ln);
        expQ.push_back(g);
    endtask

    task automatic applyStimulus(input logic [3:0][7:0] d, input logic [5:0] t, input logic [15:0] wc,
                                 input logic en, input logic fs, input logic fe);
        image_data        = d;
        image_data_type   = t;
        word_count        = wc;
        image_data_enable = en;
        frame_start       = fs;
        frame_end         = fe;
        @(posedge clk);
        #1;
        image_data_enable = 1'b0;
        frame_start       = 1'b0;
        frame_end         = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus('0, 6'h00, 16'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sendAligned(input int ln);
        pushGroup(grp(10'h048, 10'h0D1, 10'h15A, 10'h1E3), 1'b1, 1'b1, ln);
        applyStimulus(mk(8'h12, 8'h34, 8'h56, 8'h78), 6'h2B, 16'd5, 1'b1, 1'b0, 1'b0);
        applyStimulus(mk(8'hE4, 8'hAA, 8'hBB, 8'hCC), 6'h2B, 16'd5, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: every presented group must match the oldest expectation
    always @(negedge clk) begin : monitor
        group_t a, e;
        if (pixel_enable === 1'b1) begin
            a.pix = pixel; a.ls = line_start; a.le = line_end; a.ln = line_number;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_group", 64'(pixel_enable), 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("group", 64'(a), 64'(e));
            end
        end
    end

    initial begin
        reset = 1'b1;
        image_data = '0; image_data_type = '0; image_data_enable = 1'b0;
        word_count = '0; frame_start = 1'b0; frame_end = 1'b0;
        for (int i = 0; i < 20; i++) c[i] = 8'h20 + 8'(i);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_pixel_enable", pixel_enable, 0);
        checkOutput("reset_pixel", pixel, 0);
        checkOutput("reset_markers", {line_start, line_end}, 0);
        checkOutput("reset_line_number", line_number, 0);
        checkOutput("reset_frame_strobes", {frame_start_out, frame_end_out}, 0);
        checkOutput("reset_format_err", format_err, 0);
        reset = 1'b0;
        idle(1);

        // Aligned single-group RAW10 line, padding ignored
        pushGroup(grp(10'h048, 10'h0D1, 10'h15A, 10'h1E3), 1'b1, 1'b1, 0);
        applyStimulus(mk(8'h12, 8'h34, 8'h56, 8'h78), 6'h2B, 16'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("raw10_no_early_group", pixel_enable, 0);
        applyStimulus(mk(8'hE4, 8'hAA, 8'hBB, 8'hCC), 6'h2B, 16'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("raw10_latency", pixel_enable, 1);
        idle(2);
        checkOutput("line_number_after_line", line_number, 1);
        checkOutput("aligned_no_err", format_err, 0);

        // Multi-line frame: three 10-byte RAW10 lines
        applyStimulus('0, 6'h00, 16'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("frame_start_out", frame_start_out, 1);
        checkOutput("line_number_cleared", line_number, 0);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] b [10];
            for (int i = 0; i < 10; i++) b[i] = 8'h40 + 8'(k * 16) + 8'(i);
            applyStimulus(mk(b[0], b[1], b[2], b[3]), 6'h2B, 16'd10, 1'b1, 1'b0, 1'b0);
            pushGroup(r10(b[0], b[1], b[2], b[3], b[4]), 1'b1, 1'b0, k);
            applyStimulus(mk(b[4], b[5], b[6], b[7]), 6'h2B, 16'd10, 1'b1, 1'b0, 1'b0);
            pushGroup(r10(b[5], b[6], b[7], b[8], b[9]), 1'b0, 1'b1, k);
            applyStimulus(mk(b[8], b[9], 8'h00, 8'h00), 6'h2B, 16'd10, 1'b1, 1'b0, 1'b0);
        end
        idle(1);
        applyStimulus('0, 6'h00, 16'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("frame_end_out", frame_end_out, 1);
        checkOutput("frame_start_out_low", frame_start_out, 0);
        idle(1);
        checkOutput("frame_end_out_pulse", frame_end_out, 0);
        checkOutput("line_number_three", line_number, 3);
        applyStimulus('0, 6'h00, 16'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("line_number_cleared_again", line_number, 0);

        // RAW8 with partial final group, then a filtered data type
        pushGroup(grp(10'h3FC, 10'h004, 10'h008, 10'h00C), 1'b1, 1'b0, 0);
        applyStimulus(mk(8'hFF, 8'h01, 8'h02, 8'h03), 6'h2A, 16'd6, 1'b1, 1'b0, 1'b0);
        pushGroup(grp(10'h010, 10'h014, 10'h000, 10'h000), 1'b0, 1'b1, 0);
        applyStimulus(mk(8'h04, 8'h05, 8'hEE, 8'hEE), 6'h2A, 16'd6, 1'b1, 1'b0, 1'b0);
        applyStimulus(mk(8'h11, 8'h22, 8'h33, 8'h44), 6'h12, 16'd8, 1'b1, 1'b0, 1'b0);
        applyStimulus(mk(8'h55, 8'h66, 8'h77, 8'h88), 6'h12, 16'd8, 1'b1, 1'b0, 1'b0);
        checkOutput("drop_no_pixel", pixel_enable, 0);
        idle(1);
        checkOutput("drop_no_pixel_late", pixel_enable, 0);
        checkOutput("drop_no_err", format_err, 0);
        checkOutput("drop_line_number", line_number, 1);

        // Unaligned RAW10: 20 bytes in 5 words -> 4 groups
        for (int w = 0; w < 5; w++) begin
            if (w > 0) pushGroup(r10(c[5*(w-1)], c[5*(w-1)+1], c[5*(w-1)+2], c[5*(w-1)+3], c[5*(w-1)+4]),
                                 w == 1, w == 4, 1);
            applyStimulus(mk(c[4*w], c[4*w+1], c[4*w+2], c[4*w+3]), 6'h2B, 16'd20, 1'b1, 1'b0, 1'b0);
            checkOutput("unaligned_pixel_enable", pixel_enable, (w > 0) ? 1 : 0);
        end
        sendAligned(2);

        // Format error: 7-byte RAW10 line
        applyStimulus(mk(8'hA0, 8'hA1, 8'hA2, 8'hA3), 6'h2B, 16'd7, 1'b1, 1'b0, 1'b0);
        pushGroup(r10(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4), 1'b1, 1'b1, 3);
        applyStimulus(mk(8'hA4, 8'hA5, 8'hA6, 8'h00), 6'h2B, 16'd7, 1'b1, 1'b0, 1'b0);
        checkOutput("fmt_err_set", format_err, 1);
        idle(3);
        checkOutput("fmt_err_sticky", format_err, 1);
        sendAligned(4);
        applyStimulus('0, 6'h00, 16'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("fmt_err_cleared", format_err, 0);

        // word_count of zero
        applyStimulus(mk(8'h01, 8'h02, 8'h03, 8'h04), 6'h2B, 16'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("wc0_no_pixel", pixel_enable, 0);
        checkOutput("wc0_err", format_err, 1);
        idle(2);
        checkOutput("wc0_no_marker", line_number, 0);
        sendAligned(0);

        // Reset in the middle of a 20-byte RAW10 packet
        applyStimulus(mk(c[0], c[1], c[2], c[3]), 6'h2B, 16'd20, 1'b1, 1'b0, 1'b0);
        pushGroup(r10(c[0], c[1], c[2], c[3], c[4]), 1'b1, 1'b0, 1);
        applyStimulus(mk(c[4], c[5], c[6], c[7]), 6'h2B, 16'd20, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset_pixel_enable", pixel_enable, 0);
        checkOutput("midreset_pixel", pixel, 0);
        checkOutput("midreset_line_start", line_start, 0);
        checkOutput("midreset_line_number", line_number, 0);
        checkOutput("midreset_format_err", format_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sendAligned(0);

        // frame_start coinciding with an enable mid-packet
        applyStimulus(mk(c[0], c[1], c[2], c[3]), 6'h2B, 16'd20, 1'b1, 1'b0, 1'b0);
        pushGroup(grp(10'h048, 10'h0D1, 10'h15A, 10'h1E3), 1'b1, 1'b1, 0);
        applyStimulus(mk(8'h12, 8'h34, 8'h56, 8'h78), 6'h2B, 16'd5, 1'b1, 1'b1, 1'b0);
        checkOutput("fs_with_enable_out", frame_start_out, 1);
        applyStimulus(mk(8'hE4, 8'hAA, 8'hBB, 8'hCC), 6'h2B, 16'd5, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Line counter saturation with one-group RAW8 lines
        applyStimulus('0, 6'h00, 16'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2049; k++) begin
            logic [7:0] b;
            b = 8'(k);
            pushGroup(grp({b, 2'b00}, {~b, 2'b00}, 10'h168, 10'h294), 1'b1, 1'b1, (k > 2047) ? 2047 : k);
            applyStimulus(mk(b, ~b, 8'h5A, 8'hA5), 6'h2A, 16'd4, 1'b1, 1'b0, 1'b0);
        end
        idle(3);
        checkOutput("line_number_saturated", line_number, 11'h7FF);

        idle(2);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule

// File: doc/csi_raw_unpacker.md
Name: csi_raw_unpacker

Overview:
- Sits directly downstream of the CSI-2 `camera` receiver, in the MIPI byte-clock domain.
- Consumes the receiver's 4-byte image words plus packet and frame strobes, and unpacks RAW10 (type 0x2B) or RAW8 (type 0x2A) long packets into groups of four 10-bit pixels.
- Adds line_start/line_end markers and a line counter for the frame buffer / debayer stage.
- Other data types are dropped.

Parameters:
- LINE_BITS, 11: width of line_number; the counter saturates at all-ones.
- ACCEPT_RAW8, 1: when 1, type 0x2A packets are unpacked as pixel = {byte, 2'b00}; when 0, they are dropped like any other type.

Ports:
- clk  input  1  MIPI byte clock (drives the camera receiver outputs).
- reset  input  1  asynchronous, active-high reset.
- image_data  input  8 x [3:0]  received bytes; image_data[0] is the earliest byte on the wire.
- image_data_type  input  6  CSI-2 data type of the current packet.
- image_data_enable  input  1  image_data holds a valid word this cycle.
- word_count  input  16  byte length of the current long packet.
- frame_start  input  1  one-cycle Frame Start strobe.
- frame_end  input  1  one-cycle Frame End strobe.
- pixel  output  10 x [3:0]  unpacked pixels; pixel[0] is leftmost.
- pixel_enable  output  1  pixel valid this cycle.
- line_start  output  1  first pixel group of a line.
- line_end  output  1  last pixel group of a line.
- line_number  output  LINE_BITS  line index within the frame, 0-based.
- frame_start_out  output  1  frame_start delayed 1 cycle.
- frame_end_out  output  1  frame_end delayed 1 cycle.
- format_err  output  1  sticky error flag; cleared by frame_start.

Behaviour:
- Reset values:
  - All outputs 0 (pixel array 0, line_number 0).
  - Byte buffer count 0, packet remaining 0, state IDLE.
- Packet states: IDLE, RAW10, RAW8, DROP.
  - In IDLE, the first image_data_enable cycle latches word_count into remaining and selects the state from image_data_type:
    - 0x2B -> RAW10.
    - 0x2A with ACCEPT_RAW8 -> RAW8.
    - anything else -> DROP.
  - That same cycle's word is processed in the selected state.
- Byte consumption:
  - Each enable cycle consumes min(4, remaining) bytes; bytes beyond remaining (packet padding) are ignored.
  - remaining decrements by the bytes taken.
  - When remaining reaches 0 the state returns to IDLE on the next edge.
- RAW10 gearbox:
  - 8-byte buffer with count 0..8; accepted bytes are appended.
  - When count >= 5, emit one group from the oldest 5 bytes B0..B4: pixel[i] = {Bi, B4[2i+1:2i]}; count -= 5.
  - Count after emission is always <= 4, so at most one group is emitted per cycle and no backpressure exists.
- RAW8: each accepted byte yields one pixel.
  - A group is emitted when 4 pixels have accumulated.
  - A partial group at line end is emitted with missing pixels = 0.
- Latency: exactly 1 cycle from the enable cycle that completes a group to pixel_enable.
- Line markers:
  - line_start accompanies the first group of a RAW10/RAW8 packet.
  - line_end accompanies the group that consumes the packet's last byte.
  - Both may be asserted together for a one-group line.
  - line_number increments on the cycle after line_end and is held during the line.
- Format errors (format_err set):
  - RAW10 word_count not a multiple of 5: on reaching remaining==0 with leftover bytes, the leftovers are discarded, line_end is still asserted on the last full group, and the buffer count is cleared to 0.
  - word_count == 0: no pixels and no markers; the state returns to IDLE.
  - An enable cycle while in DROP never sets format_err.
- Frame strobes:
  - frame_start clears line_number, format_err, buffer count, remaining, and forces IDLE.
  - If frame_start and image_data_enable occur in the same cycle, frame_start acts first and the word is treated as the first word of line 0.
  - frame_end registers out 1 cycle later; its only other effect is to force IDLE after any in-flight group emits.
- Reset mid-packet: everything returns to reset values immediately; the next enable cycle is treated as a new packet header.

Test Plan:
- Aligned RAW10 line:
  - Stimulus: type 0x2B, word_count=5; word0 = 12,34,56,78; word1 = E4,xx,xx,xx.
  - Response: one group pixel = 048, 0D1, 15A, 1E3, one cycle after word1; line_start=line_end=1; line_number=0; the three padding bytes are ignored.
- Unaligned RAW10 line:
  - Stimulus: word_count=20 in 5 consecutive enable cycles.
  - Response: exactly 4 groups; no idle gap violations; line_end on the 4th group only; buffer count=0 afterwards.
- Multi-line frame:
  - Stimulus: frame_start, three RAW10 lines of 10 bytes, frame_end.
  - Response: line_number 0, 1, 2 on the respective groups; frame_start_out/frame_end_out each delayed 1 cycle; line_number cleared by the next frame_start.
- RAW8 and filtering:
  - Stimulus: type 0x2A word_count=6 with bytes FF,01,...; then type 0x12 word_count=8.
  - Response: groups {3FC,004,...} then a partial group padded with 0 carrying line_end; the 0x12 packet produces no pixel_enable and no error.
- Format error:
  - Stimulus: RAW10 word_count=7.
  - Response: one group with line_end; the 2 leftover bytes are discarded; format_err=1 until the next frame_start.
- Reset and frame_start mid-packet:
  - Stimulus: assert reset after 2 words of a 20-byte RAW10 packet; alternatively assert frame_start in the same cycle as an enable.
  - Response: all outputs 0 immediately on reset; the following word is treated as a new packet header with line_number=0.
